// File: rtl/sudoku_game_ctrl.sv
// Sudoku game controller: difficulty select, hint preload, guess entry and
// check handshake with the datapath. It also tracks a lives budget, a check
// timeout, and the WIN (FIN) and LOSE (LOST) terminal states.
module sudoku_game_ctrl #(
  parameter  int CELLS      = 16,
  parameter  int EASY_HINTS = 4,
  parameter  int MED_HINTS  = 3,
  parameter  int HARD_HINTS = 2,
  parameter  int MAX_WRONG  = 3,
  parameter  int CHECK_TMO  = 64,
  localparam int IDX_W      = $clog2(CELLS),
  localparam int LIFE_W     = $clog2(MAX_WRONG + 1)
) (
  input  logic              clka,
  input  logic              restart_n,
  input  logic              enter,
  input  logic [1:0]        difficulty,
  input  logic              check_done,
  input  logic              solved,
  output logic [3:0]        state,
  output logic              dp_check,
  output logic              hint_we,
  output logic [IDX_W-1:0]  hint_idx,
  output logic [CELLS-1:0]  fill_flag,
  output logic [LIFE_W-1:0] lives,
  output logic              won,
  output logic              lost,
  output logic              busy
);

  // Hint counter is one bit wider than the index so it can hold CELLS itself.
  localparam int CNT_W     = IDX_W + 1;
  localparam int TMO_W     = (CHECK_TMO > 1) ? $clog2(CHECK_TMO) : 1;
  localparam int EASY_N_I  = (EASY_HINTS < CELLS) ? EASY_HINTS : CELLS;
  localparam int MED_N_I   = (MED_HINTS  < CELLS) ? MED_HINTS  : CELLS;
  localparam int HARD_N_I  = (HARD_HINTS < CELLS) ? HARD_HINTS : CELLS;

  localparam logic [CNT_W-1:0]  EASY_N     = CNT_W'(EASY_N_I);
  localparam logic [CNT_W-1:0]  MED_N      = CNT_W'(MED_N_I);
  localparam logic [CNT_W-1:0]  HARD_N     = CNT_W'(HARD_N_I);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(CHECK_TMO - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(MAX_WRONG);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SET_DIFF   = 4'd1,
    LOAD_HINTS = 4'd2,
    REG_INP    = 4'd3,
    GUESS      = 4'd4,
    CHECK      = 4'd5,
    WRONG      = 4'd6,
    FIN        = 4'd7,
    LOST       = 4'd8
  } state_e;

  state_e              state_q, state_d;
  logic                enter_q;
  logic                enter_rise;
  logic                dp_check_q, dp_check_d;
  logic                hint_we_q, hint_we_d;
  logic [IDX_W-1:0]    hint_idx_q, hint_idx_d;
  logic [CELLS-1:0]    fill_flag_q, fill_flag_d;
  logic [LIFE_W-1:0]   lives_q, lives_d;
  logic                won_q, won_d;
  logic                lost_q, lost_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    hint_cnt_q, hint_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    hint_sel;
  logic [IDX_W-1:0]    next_idx;
  logic                more_hints;
  logic [LIFE_W-1:0]   lives_dec;

  assign enter_rise = enter & ~enter_q;
  assign next_idx   = hint_idx_q + IDX_W'(1);
  assign more_hints = ({1'b0, hint_idx_q} + CNT_W'(1)) < hint_cnt_q;
  assign lives_dec  = (lives_q == '0) ? '0 : lives_q - LIFE_W'(1);

  // Map the selected difficulty to its (clamped) hint count.
  always_comb begin
    hint_sel = '0;
    case (difficulty)
      2'b01:   hint_sel = EASY_N;
      2'b10:   hint_sel = MED_N;
      2'b11:   hint_sel = HARD_N;
      default: hint_sel = '0;
    endcase
  end

  // Next-state logic plus the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    dp_check_d  = 1'b0;
    hint_we_d   = 1'b0;
    hint_idx_d  = hint_idx_q;
    fill_flag_d = fill_flag_q;
    lives_d     = lives_q;
    hint_cnt_d  = hint_cnt_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        fill_flag_d = '0;
        hint_idx_d  = '0;
        state_d     = SET_DIFF;
      end
      SET_DIFF: begin
        if (enter_rise && (difficulty != 2'b00)) begin
          hint_cnt_d = hint_sel;
          lives_d    = LIVES_INIT;
          hint_idx_d = '0;
          state_d    = LOAD_HINTS;
          if (hint_sel != '0) begin
            hint_we_d      = 1'b1;
            fill_flag_d[0] = 1'b1;
          end
        end
      end
      LOAD_HINTS: begin
        if (more_hints) begin
          hint_we_d             = 1'b1;
          hint_idx_d            = next_idx;
          fill_flag_d[next_idx] = 1'b1;
        end else begin
          state_d = REG_INP;
        end
      end
      REG_INP: begin
        if (enter_rise) state_d = GUESS;
      end
      GUESS: begin
        if (enter_rise) begin
          state_d    = CHECK;
          dp_check_d = 1'b1;
          tmo_d      = '0;
        end
      end
      CHECK: begin
        if (check_done) begin
          if (solved) begin
            state_d = FIN;
          end else begin
            state_d = WRONG;
            lives_d = lives_dec;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = WRONG;
          lives_d = lives_dec;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WRONG: begin
        if (lives_q == '0)   state_d = LOST;
        else if (enter_rise) state_d = REG_INP;
      end
      FIN, LOST: begin
        if (enter_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) fill_flag_d = '0;
    won_d  = (state_d == FIN);
    lost_d = (state_d == LOST);
    busy_d = (state_d == LOAD_HINTS) || (state_d == CHECK);
  end

  // State and output registers with synchronous active-low restart.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state_q     <= IDLE;
      enter_q     <= 1'b0;
      dp_check_q  <= 1'b0;
      hint_we_q   <= 1'b0;
      hint_idx_q  <= '0;
      fill_flag_q <= '0;
      lives_q     <= LIVES_INIT;
      won_q       <= 1'b0;
      lost_q      <= 1'b0;
      busy_q      <= 1'b0;
      hint_cnt_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      enter_q     <= enter;
      dp_check_q  <= dp_check_d;
      hint_we_q   <= hint_we_d;
      hint_idx_q  <= hint_idx_d;
      fill_flag_q <= fill_flag_d;
      lives_q     <= lives_d;
      won_q       <= won_d;
      lost_q      <= lost_d;
      busy_q      <= busy_d;
      hint_cnt_q  <= hint_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign state     = state_q;
  assign dp_check  = dp_check_q;
  assign hint_we   = hint_we_q;
  assign hint_idx  = hint_idx_q;
  assign fill_flag = fill_flag_q;
  assign lives     = lives_q;
  assign won       = won_q;
  assign lost      = lost_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Self-checking bench for sudoku_game_ctrl: scenario tasks with randomized
// delays and outcomes, checked against a game-level reference model.
module tb_sudoku_game_ctrl;

  localparam int CELLS = 16;
  localparam int EASY  = 4;
  localparam int MED   = 3;
  localparam int HARD  = 2;
  localparam int MAXW  = 3;
  localparam int TMO   = 64;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SET   = 4'd1;
  localparam logic [3:0] S_LOAD  = 4'd2;
  localparam logic [3:0] S_REG   = 4'd3;
  localparam logic [3:0] S_GUESS = 4'd4;
  localparam logic [3:0] S_CHECK = 4'd5;
  localparam logic [3:0] S_WRONG = 4'd6;
  localparam logic [3:0] S_FIN   = 4'd7;
  localparam logic [3:0] S_LOST  = 4'd8;

  logic        clka = 1'b0;
  logic        restart_n = 1'b0;
  logic        enter = 1'b0;
  logic [1:0]  difficulty = 2'b00;
  logic        check_done = 1'b0;
  logic        solved = 1'b0;

  logic [3:0]  state, z_state;
  logic        dp_check, z_dp_check;
  logic        hint_we, z_hint_we;
  logic [3:0]  hint_idx, z_hint_idx;
  logic [15:0] fill_flag, z_fill_flag;
  logic [1:0]  lives, z_lives;
  logic        won, z_won, lost, z_lost, busy, z_busy;

  int          checks = 0;
  int          errors = 0;
  int          model_lives;
  bit          model_over;
  logic [15:0] model_fill;

  sudoku_game_ctrl u_dut (
    .clka(clka), .restart_n(restart_n), .enter(enter), .difficulty(difficulty),
    .check_done(check_done), .solved(solved), .state(state), .dp_check(dp_check),
    .hint_we(hint_we), .hint_idx(hint_idx), .fill_flag(fill_flag), .lives(lives),
    .won(won), .lost(lost), .busy(busy)
  );

  sudoku_game_ctrl #(.HARD_HINTS(0)) u_dut_zero (
    .clka(clka), .restart_n(restart_n), .enter(enter), .difficulty(difficulty),
    .check_done(check_done), .solved(solved), .state(z_state), .dp_check(z_dp_check),
    .hint_we(z_hint_we), .hint_idx(z_hint_idx), .fill_flag(z_fill_flag), .lives(z_lives),
    .won(z_won), .lost(z_lost), .busy(z_busy)
  );

  always #5 clka = ~clka;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int hints_for(input logic [1:0] d);
    int h;
    case (d)
      2'b01:   h = EASY;
      2'b10:   h = MED;
      2'b11:   h = HARD;
      default: h = 0;
    endcase
    return (h < CELLS) ? h : CELLS;
  endfunction

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    restart_n  = 1'b0;
    enter      = 1'b0;
    check_done = 1'b0;
    solved     = 1'b0;
    difficulty = 2'b00;
    tick();
    tick();
    restart_n  = 1'b1;
    tick();
    model_over = 1'b0;
  endtask

  task automatic load_game(input logic [1:0] d);
    int n;
    logic [15:0] fexp;
    n = hints_for(d);
    model_fill = '0;
    for (int b = 0; b < n; b++) model_fill[b] = 1'b1;
    model_lives = MAXW;
    difficulty = d;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    difficulty = 2'($urandom_range(0, 3));
    for (int k = 0; k < n; k++) begin
      fexp = '0;
      for (int b = 0; b <= k; b++) fexp[b] = 1'b1;
      checks++;
      if (hint_we !== 1'b1 || hint_idx !== 4'(k) || fill_flag !== fexp ||
          state !== S_LOAD || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL load_step%0d: got we=%b idx=%0d fill=%h state=%0d busy=%b, expected we=1 idx=%0d fill=%h state=%0d busy=1",
                 k, hint_we, hint_idx, fill_flag, state, busy, k, fexp, S_LOAD);
      end
      tick();
    end
    checks++;
    if (state !== S_REG || hint_we !== 1'b0 || fill_flag !== model_fill ||
        lives !== 2'(MAXW) || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_done: got state=%0d we=%b fill=%h lives=%0d busy=%b, expected state=%0d we=0 fill=%h lives=%0d busy=0",
               state, hint_we, fill_flag, lives, busy, S_REG, model_fill, MAXW);
    end
  endtask

  // From REG_INP: two enter presses, then resolve the check (or let it time out).
  task automatic run_check(input int delay, input bit give_done, input bit sol);
    bit expect_win;
    bit stayed;
    expect_win = give_done && sol;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    checks++;
    if (state !== S_GUESS) begin
      errors++;
      $display("[TB] FAIL guess_entry: got state=%0d expected %0d", state, S_GUESS);
    end
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    checks++;
    if (state !== S_CHECK || dp_check !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL check_entry: got state=%0d dp_check=%b busy=%b expected state=%0d dp_check=1 busy=1",
               state, dp_check, busy, S_CHECK);
    end
    if (give_done) begin
      if (delay > 0) begin
        tick();
        checks++;
        if (dp_check !== 1'b0 || state !== S_CHECK) begin
          errors++;
          $display("[TB] FAIL dp_check_pulse: got dp_check=%b state=%0d expected dp_check=0 state=%0d",
                   dp_check, state, S_CHECK);
        end
        for (int i = 1; i < delay; i++) tick();
      end
      check_done = 1'b1;
      solved     = sol;
      tick();
      check_done = 1'b0;
      solved     = 1'($urandom_range(0, 1));
    end else begin
      stayed = 1'b1;
      for (int i = 1; i < TMO; i++) begin
        tick();
        if (state !== S_CHECK) stayed = 1'b0;
      end
      checks++;
      if (!stayed) begin
        errors++;
        $display("[TB] FAIL timeout_hold: got early exit from CHECK expected %0d cycles in CHECK", TMO);
      end
      tick();
    end
    if (expect_win) begin
      model_over = 1'b1;
      checks++;
      if (state !== S_FIN || won !== 1'b1 || lost !== 1'b0 || lives !== 2'(model_lives) || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL win_result: got state=%0d won=%b lost=%b lives=%0d busy=%b expected state=%0d won=1 lost=0 lives=%0d busy=0",
                 state, won, lost, lives, busy, S_FIN, model_lives);
      end
    end else begin
      model_lives = (model_lives > 0) ? model_lives - 1 : 0;
      checks++;
      if (state !== S_WRONG || lives !== 2'(model_lives) || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrong_result: got state=%0d lives=%0d busy=%b expected state=%0d lives=%0d busy=0",
                 state, lives, busy, S_WRONG, model_lives);
      end
      tick();
      if (model_lives == 0) begin
        model_over = 1'b1;
        checks++;
        if (state !== S_LOST || lost !== 1'b1 || won !== 1'b0 || fill_flag !== model_fill) begin
          errors++;
          $display("[TB] FAIL lost_state: got state=%0d lost=%b won=%b fill=%h expected state=%0d lost=1 won=0 fill=%h",
                   state, lost, won, fill_flag, S_LOST, model_fill);
        end
      end else begin
        checks++;
        if (state !== S_WRONG) begin
          errors++;
          $display("[TB] FAIL wrong_wait: got state=%0d expected %0d", state, S_WRONG);
        end
        enter = 1'b1;
        tick();
        enter = 1'b0;
        checks++;
        if (state !== S_REG || fill_flag !== model_fill) begin
          errors++;
          $display("[TB] FAIL wrong_resume: got state=%0d fill=%h expected state=%0d fill=%h",
                   state, fill_flag, S_REG, model_fill);
        end
        tick();
      end
    end
  endtask

  task automatic test_reset();
    restart_n = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== S_IDLE || lives !== 2'(MAXW) || dp_check !== 1'b0 || hint_we !== 1'b0 ||
        hint_idx !== 4'd0 || fill_flag !== 16'h0000 || won !== 1'b0 || lost !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got state=%0d lives=%0d dp=%b we=%b idx=%0d fill=%h won=%b lost=%b busy=%b expected state=0 lives=%0d rest 0",
               state, lives, dp_check, hint_we, hint_idx, fill_flag, won, lost, busy, MAXW);
    end
    restart_n = 1'b1;
    tick();
    checks++;
    if (state !== S_SET) begin
      errors++;
      $display("[TB] FAIL idle_to_set: got state=%0d expected %0d", state, S_SET);
    end
  endtask

  task automatic test_easy_flow();
    do_reset();
    load_game(2'b01);
    checks++;
    if (fill_flag !== 16'h000F) begin
      errors++;
      $display("[TB] FAIL easy_fill: got %h expected 000f", fill_flag);
    end
  endtask

  task automatic test_win();
    run_check(3, 1'b1, 1'b1);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    checks++;
    if (state !== S_IDLE || won !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fin_to_idle: got state=%0d won=%b expected state=%0d won=0", state, won, S_IDLE);
    end
    tick();
    checks++;
    if (state !== S_SET || fill_flag !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL new_game: got state=%0d fill=%h expected state=%0d fill=0000", state, fill_flag, S_SET);
    end
  endtask

  task automatic test_lose();
    do_reset();
    load_game(2'b11);
    for (int c = 0; c < 3; c++) run_check($urandom_range(0, 10), 1'b1, 1'b0);
    checks++;
    if (fill_flag !== 16'h0003 || lives !== 2'd0 || lost !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lose_final: got fill=%h lives=%0d lost=%b expected fill=0003 lives=0 lost=1",
               fill_flag, lives, lost);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    load_game(2'b10);
    run_check(0, 1'b0, 1'b0);
    checks++;
    if (lives !== 2'd2) begin
      errors++;
      $display("[TB] FAIL timeout_lives: got %0d expected 2", lives);
    end
    run_check(TMO - 1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    difficulty = 2'b01;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    checks++;
    if (hint_we !== 1'b1 || hint_idx !== 4'd1) begin
      errors++;
      $display("[TB] FAIL second_write: got we=%b idx=%0d expected we=1 idx=1", hint_we, hint_idx);
    end
    restart_n = 1'b0;
    tick();
    restart_n = 1'b1;
    checks++;
    if (state !== S_IDLE || fill_flag !== 16'h0000 || hint_we !== 1'b0 || lives !== 2'(MAXW)) begin
      errors++;
      $display("[TB] FAIL reset_mid_load: got state=%0d fill=%h we=%b lives=%0d expected state=0 fill=0000 we=0 lives=%0d",
               state, fill_flag, hint_we, lives, MAXW);
    end
    do_reset();
    load_game(2'b11);
    enter = 1'b1; tick(); enter = 1'b0; tick();
    enter = 1'b1; tick(); enter = 1'b0;
    restart_n = 1'b0;
    tick();
    restart_n = 1'b1;
    checks++;
    if (state !== S_IDLE || dp_check !== 1'b0 || busy !== 1'b0 || fill_flag !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_mid_check: got state=%0d dp=%b busy=%b fill=%h expected state=0 dp=0 busy=0 fill=0000",
               state, dp_check, busy, fill_flag);
    end
  endtask

  task automatic test_edge_cases();
    do_reset();
    difficulty = 2'b00;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    checks++;
    if (state !== S_SET || hint_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL diff_zero: got state=%0d we=%b expected state=%0d we=0", state, hint_we, S_SET);
    end
    tick();
    load_game(2'b10);
    enter = 1'b1;
    repeat (5) tick();
    checks++;
    if (state !== S_GUESS) begin
      errors++;
      $display("[TB] FAIL held_enter: got state=%0d expected %0d", state, S_GUESS);
    end
    enter = 1'b0;
    tick();
    check_done = 1'b1;
    solved = 1'b1;
    tick();
    check_done = 1'b0;
    checks++;
    if (state !== S_GUESS || won !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_outside_check: got state=%0d won=%b expected state=%0d won=0", state, won, S_GUESS);
    end
    enter = 1'b1; tick(); enter = 1'b0;
    tick();
    enter = 1'b1; tick(); enter = 1'b0;
    checks++;
    if (state !== S_CHECK || dp_check !== 1'b0) begin
      errors++;
      $display("[TB] FAIL enter_in_check: got state=%0d dp=%b expected state=%0d dp=0", state, dp_check, S_CHECK);
    end
    check_done = 1'b1;
    solved = 1'b1;
    tick();
    check_done = 1'b0;
    checks++;
    if (state !== S_FIN || won !== 1'b1 || lives !== 2'(MAXW)) begin
      errors++;
      $display("[TB] FAIL edge_win: got state=%0d won=%b lives=%0d expected state=%0d won=1 lives=%0d",
               state, won, lives, S_FIN, MAXW);
    end
  endtask

  task automatic test_zero_hints();
    bit seen_we;
    bit reached;
    do_reset();
    difficulty = 2'b11;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    seen_we = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (z_hint_we === 1'b1) seen_we = 1'b1;
      if (z_state === S_REG) reached = 1'b1;
      tick();
    end
    checks++;
    if (seen_we || !reached || z_fill_flag !== 16'h0000 || z_lives !== 2'(MAXW)) begin
      errors++;
      $display("[TB] FAIL zero_hints: got seen_we=%b reached_reg=%b fill=%h lives=%0d expected seen_we=0 reached_reg=1 fill=0000 lives=%0d",
               seen_we, reached, z_fill_flag, z_lives, MAXW);
    end
  endtask

  task automatic test_random();
    logic [1:0] d;
    bit give;
    for (int g = 0; g < 5; g++) begin
      do_reset();
      d = 2'($urandom_range(1, 3));
      load_game(d);
      for (int c = 0; c < 6 && !model_over; c++) begin
        give = ($urandom_range(0, 5) != 0);
        run_check($urandom_range(0, TMO - 1), give, ($urandom_range(0, 2) == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_easy_flow();
    test_win();
    test_lose();
    test_timeout();
    test_reset_mid_load();
    test_edge_cases();
    test_zero_hints();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
